// File: rtl/tmu_perfsnap.sv
// ---------------------------------------------------------------------------
// tmu_perfsnap
//   Takes a snapshot of the seven live TMU performance counters into shadow
//   registers once per completed run. Software reads the shadows and the
//   status through a CSR bank while the next run is counting. irq pulses for
//   one cycle after each capture.
//
//   A run is detected from the start pulse and the busy falling edge. One
//   settle cycle lets the final counter increments land before the capture.
//   A start that arrives before the capture aborts the current run: abort_cnt
//   counts up and no capture is taken.
//
//   Optional build macro: TMU_PERFSNAP_ACCUM_EN adds 64-bit accumulators for
//   clocks and pixels (CSR 9..12). A status write with bit1 set clears them.
//
// Ports
//   sys_clk, sys_rst_n    clock, synchronous active-low reset
//   start, busy           run start pulse and TMU busy
//   perf_*                live 32-bit counter values
//   csr_a/we/di           CSR address, write strobe, write data
//   csr_do                registered CSR read data (0 when not selected)
//   irq                   one-cycle pulse on the cycle after a capture
//
// CSR map (word index csr_a[3:0], bank csr_a[13:10] == csr_addr)
//   0     status/ctrl: R {run_cnt[15:8], overrun[2], running[1], valid[0]}
//                      W bit0 clear valid, bit2 clear overrun, bit1 clear acc
//   1..7  shadow pixels, clocks, stall1, complete1, stall2, complete2, misses
//   8     abort_cnt (16-bit, saturating)
//   9..12 acc_clocks lo/hi, acc_pixels lo/hi (0 without the macro)
// ---------------------------------------------------------------------------
module tmu_perfsnap #(
   parameter logic [3:0] csr_addr = 4'h0
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        start,
   input  logic        busy,
   input  logic [31:0] perf_pixels,
   input  logic [31:0] perf_clocks,
   input  logic [31:0] perf_stall1,
   input  logic [31:0] perf_complete1,
   input  logic [31:0] perf_stall2,
   input  logic [31:0] perf_complete2,
   input  logic [31:0] perf_misses,
   input  logic [13:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do,
   output logic        irq
);

   localparam int NUM_CNT = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      SETTLE  = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic                          busy_r;
   logic                          capture;
   logic                          abort_evt;
   logic [NUM_CNT-1:0][31:0]      live;
   logic [NUM_CNT-1:0][31:0]      shadow;
   logic [7:0]                    run_cnt;
   logic [15:0]                   abort_cnt;
   logic                          valid;
   logic                          overrun;

   logic                          csr_sel;
   logic [3:0]                    csr_idx;
   logic [2:0]                    sh_idx;
   logic                          st_wr;
   logic                          clr_valid;
   logic                          clr_ovr;
   logic [31:0]                   rd_data;

   // Entry 0 is pixels, matching CSR word 1.
   assign live = {perf_misses, perf_complete2, perf_stall2, perf_complete1,
                  perf_stall1, perf_clocks, perf_pixels};

   // ------------------------------------------------------------------------
   // Run sequencing
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      abort_evt = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            // A restart counts as an abort and takes priority over the fall.
            if (start) begin
               abort_evt = 1'b1;
            end else if (busy_r && !busy) begin
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (start) begin
               abort_evt = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            // The capture always completes. A start here begins the next run.
            capture   = 1'b1;
            state_nxt = start ? RUN : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state  <= IDLE;
         busy_r <= 1'b0;
         irq    <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_r <= busy;
         irq    <= capture;
      end
   end

   // ------------------------------------------------------------------------
   // CSR decode
   // ------------------------------------------------------------------------
   assign csr_sel   = (csr_a[13:10] == csr_addr);
   assign csr_idx   = csr_a[3:0];
   assign sh_idx    = csr_idx[2:0] - 3'd1;   // words 1..7 map to shadows 0..6
   assign st_wr     = csr_sel && csr_we && (csr_idx == 4'd0);
   assign clr_valid = st_wr && csr_di[0];
   assign clr_ovr   = st_wr && csr_di[2];

   // ------------------------------------------------------------------------
   // Shadows and status
   // ------------------------------------------------------------------------
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         shadow    <= '0;
         run_cnt   <= '0;
         abort_cnt <= '0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (capture) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
            run_cnt <= run_cnt + 8'd1;
         end
         if (abort_evt && (abort_cnt != 16'hFFFF))
            abort_cnt <= abort_cnt + 16'd1;
         // A capture sets valid even when software clears it in that cycle.
         // overrun is set from valid as it was before any clear.
         valid   <= capture | (valid & ~clr_valid);
         overrun <= (overrun & ~clr_ovr) | (capture & valid);
      end
   end

`ifdef TMU_PERFSNAP_ACCUM_EN
   logic [63:0] acc_clocks;
   logic [63:0] acc_pixels;
   logic        clr_acc;

   assign clr_acc = st_wr && csr_di[1];

   // A clear wins over a capture in the same cycle.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n || clr_acc) begin
         acc_clocks <= '0;
         acc_pixels <= '0;
      end else if (capture) begin
         acc_clocks <= acc_clocks + {32'd0, perf_clocks};
         acc_pixels <= acc_pixels + {32'd0, perf_pixels};
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------------
   always_comb begin
      rd_data = '0;
      if (csr_sel) begin
         case (csr_idx)
            4'd0: rd_data = {16'd0, run_cnt, 5'd0, overrun,
                             (state != IDLE), valid};
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                  rd_data = shadow[sh_idx];
            4'd8: rd_data = {16'd0, abort_cnt};
`ifdef TMU_PERFSNAP_ACCUM_EN
            4'd9:  rd_data = acc_clocks[31:0];
            4'd10: rd_data = acc_clocks[63:32];
            4'd11: rd_data = acc_pixels[31:0];
            4'd12: rd_data = acc_pixels[63:32];
`endif
            default: rd_data = '0;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) csr_do <= '0;
      else            csr_do <= rd_data;
   end

   // Address and data bits outside the decoded fields.
   logic unused_bits;
   assign unused_bits = &{1'b0, csr_a[9:4], csr_di[31:3], csr_di[1]};

endmodule

// File: tb/tb_tmu_perfsnap.sv
// ---------------------------------------------------------------------------
// tb_tmu_perfsnap
//   Directed bench for tmu_perfsnap: reset state, capture timing and
//   contents, overrun, aborts, capture-cycle CSR races, mid-run reset and
//   the accumulators (expectations follow TMU_PERFSNAP_ACCUM_EN).
// ---------------------------------------------------------------------------
module tb_tmu_perfsnap;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        start, busy;
   logic [31:0] perf_pixels, perf_clocks, perf_stall1, perf_complete1;
   logic [31:0] perf_stall2, perf_complete2, perf_misses;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] cap_rd;

   tmu_perfsnap #(.csr_addr(4'h0)) dut (
      .sys_clk        (sys_clk),
      .sys_rst_n      (sys_rst_n),
      .start          (start),
      .busy           (busy),
      .perf_pixels    (perf_pixels),
      .perf_clocks    (perf_clocks),
      .perf_stall1    (perf_stall1),
      .perf_complete1 (perf_complete1),
      .perf_stall2    (perf_stall2),
      .perf_complete2 (perf_complete2),
      .perf_misses    (perf_misses),
      .csr_a          (csr_a),
      .csr_we         (csr_we),
      .csr_di         (csr_di),
      .csr_do         (csr_do),
      .irq            (irq)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] idx, input logic [31:0] exp);
      csr_a  = {4'h0, 6'd0, idx};
      csr_we = 1'b0;
      step();
      chk(tag, csr_do, exp);
   endtask

   task automatic csr_wr(input logic [3:0] idx, input logic [31:0] d);
      csr_a  = {4'h0, 6'd0, idx};
      csr_di = d;
      csr_we = 1'b1;
      step();
      csr_we = 1'b0;
      csr_di = '0;
   endtask

   // Pulse start, then hold busy for n cycles.
   task automatic start_run(input int n);
      start = 1'b1;
      step();
      start = 1'b0;
      busy  = 1'b1;
      for (int i = 0; i < n; i++) step();
   endtask

   // Drop busy and walk to the capture. The CSR access given here is driven
   // during the CAPTURE cycle; cap_rd is the data read in that cycle.
   task automatic finish_run(input string tag, input logic [3:0] cap_a,
                             input logic cap_we, input logic [31:0] cap_di,
                             output logic [31:0] rd);
      busy = 1'b0;
      step();
      chk({tag, "_irq_c1"}, {31'd0, irq}, 32'd0);
      step();
      chk({tag, "_irq_c2"}, {31'd0, irq}, 32'd0);
      csr_a  = {4'h0, 6'd0, cap_a};
      csr_we = cap_we;
      csr_di = cap_di;
      step();
      csr_we = 1'b0;
      csr_di = '0;
      rd = csr_do;
      chk({tag, "_irq_c3"}, {31'd0, irq}, 32'd1);
      step();
      chk({tag, "_irq_c4"}, {31'd0, irq}, 32'd0);
   endtask

   initial begin
      sys_rst_n = 1'b0;
      start = 1'b0; busy = 1'b0;
      perf_pixels = '0; perf_clocks = '0; perf_stall1 = '0; perf_complete1 = '0;
      perf_stall2 = '0; perf_complete2 = '0; perf_misses = '0;
      csr_a = '0; csr_we = 1'b0; csr_di = '0;
      step(); step();
      sys_rst_n = 1'b1;

      // Reset state
      chk("rst_irq", {31'd0, irq}, 32'd0);
      for (int i = 0; i <= 12; i++) rd_chk("rst_csr", 4'(i), 32'd0);

      // Run 1
      perf_pixels = 32'd100; perf_clocks = 32'd10; perf_misses = 32'd3;
      start_run(10);
      finish_run("run1", 4'd0, 1'b0, 32'd0, cap_rd);
      rd_chk("run1_pix",    4'd1, 32'd100);
      rd_chk("run1_clk",    4'd2, 32'd10);
      rd_chk("run1_miss",   4'd7, 32'd3);
      rd_chk("run1_status", 4'd0, 32'h0000_0101);
      csr_a = 14'h0401;   // other bank
      step();
      chk("bank_miss", csr_do, 32'd0);

      // Run 2 without clearing valid -> overrun
      perf_pixels = 32'd5;
      start_run(4);
      finish_run("run2", 4'd0, 1'b0, 32'd0, cap_rd);
      rd_chk("run2_status", 4'd0, 32'h0000_0205);
      rd_chk("run2_pix",    4'd1, 32'd5);
      csr_wr(4'd0, 32'h5);
      rd_chk("clr_status",  4'd0, 32'h0000_0200);
      csr_wr(4'd1, 32'hDEAD_BEEF);   // read-only word
      rd_chk("ro_pix",      4'd1, 32'd5);

      // Aborts: start in RUN, then start in SETTLE
      start_run(3);
      rd_chk("running", 4'd0, 32'h0000_0202);
      start = 1'b1; step(); start = 1'b0;
      chk("abort1_irq", {31'd0, irq}, 32'd0);
      step();
      busy = 1'b0;
      step();              // now in SETTLE
      start = 1'b1; step(); start = 1'b0;
      chk("abort2_irq", {31'd0, irq}, 32'd0);
      step();
      chk("abort2_irq_b", {31'd0, irq}, 32'd0);
      busy = 1'b1; step(); step();
      finish_run("run3", 4'd0, 1'b0, 32'd0, cap_rd);
      rd_chk("abort_cnt",   4'd8, 32'd2);
      rd_chk("run3_status", 4'd0, 32'h0000_0301);

      // Clear valid in the CAPTURE cycle: capture wins, overrun set
      start_run(3);
      finish_run("run4", 4'd0, 1'b1, 32'h1, cap_rd);
      rd_chk("run4_status", 4'd0, 32'h0000_0405);

      // Reset mid-run
      start_run(3);
      sys_rst_n = 1'b0;
      step();
      sys_rst_n = 1'b1;
      busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rst_run_irq", {31'd0, irq}, 32'd0);
      end
      rd_chk("rst_run_status", 4'd0, 32'd0);
      rd_chk("rst_run_pix",    4'd1, 32'd0);
      rd_chk("rst_run_abort",  4'd8, 32'd0);

      // Accumulator runs; CAPTURE-cycle read returns the old shadow
      perf_clocks = 32'hFFFF_FFFF; perf_pixels = 32'd7;
      start_run(2);
      finish_run("acc1", 4'd1, 1'b0, 32'd0, cap_rd);
      chk("acc1_caprd", cap_rd, 32'd0);
      perf_pixels = 32'd9;
      start_run(2);
      finish_run("acc2", 4'd1, 1'b0, 32'd0, cap_rd);
      chk("acc2_caprd", cap_rd, 32'd7);
      rd_chk("acc2_pix",    4'd1, 32'd9);
      rd_chk("acc2_status", 4'd0, 32'h0000_0205);
`ifdef TMU_PERFSNAP_ACCUM_EN
      rd_chk("acc_clk_lo", 4'd9,  32'hFFFF_FFFE);
      rd_chk("acc_clk_hi", 4'd10, 32'd1);
      rd_chk("acc_pix_lo", 4'd11, 32'd16);
      rd_chk("acc_pix_hi", 4'd12, 32'd0);
`else
      rd_chk("acc_clk_lo", 4'd9,  32'd0);
      rd_chk("acc_clk_hi", 4'd10, 32'd0);
      rd_chk("acc_pix_lo", 4'd11, 32'd0);
      rd_chk("acc_pix_hi", 4'd12, 32'd0);
`endif
      csr_wr(4'd0, 32'h2);
      for (int i = 9; i <= 12; i++) rd_chk("acc_clr", 4'(i), 32'd0);
      rd_chk("acc_clr_status", 4'd0, 32'h0000_0205);
      rd_chk("unused_word", 4'd15, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tmu_perfsnap.md
Name: tmu_perfsnap

Overview:
- Consumes the seven TMU performance counter values and the start/busy pair; downstream of the perf counter stage.
- Snapshots the counters into shadow registers once per completed run.
- Exposes the shadows and status through a CSR bank and pulses an IRQ at capture.
- Software reads a stable result while the next run is counting.

Parameters:
- csr_addr, 4'h0, CSR bank select, compared against csr_a[13:10].

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  reset: synchronous, active-low
- start  in  1  run start pulse, same signal that feeds the counters
- busy  in  1  TMU busy
- perf_pixels, perf_clocks, perf_stall1, perf_complete1, perf_stall2, perf_complete2, perf_misses  in  32 each  live counter values
- csr_a  in  14  CSR address
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered
- irq  out  1  one-cycle pulse when a snapshot is captured

Behaviour:
- Reset (sys_rst_n=0 at a clock edge) clears:
  - all shadows, run_cnt, abort_cnt, valid, overrun: 0
  - csr_do=0, irq=0
  - FSM to IDLE
  - Reset mid-run discards the run with no capture.
- FSM states and transitions:
  - IDLE: start -> RUN.
  - RUN: start -> RUN; abort_cnt+1, no capture. busy_r=1 && busy=0 -> SETTLE.
  - SETTLE: one cycle so the final counter increments land. start -> RUN; abort_cnt+1. Otherwise -> CAPTURE.
  - CAPTURE: all 7 shadows <= live counters; run_cnt+1 (8-bit, wraps 255->0); overrun <= overrun|valid; valid <= 1; irq=1 on the following cycle; -> IDLE. start in CAPTURE: capture completes and the FSM goes to RUN.
- busy_r: busy registered, cleared by reset. busy falling in IDLE is ignored.
- Capture latency: irq asserts 3 cycles after the first cycle with busy=0. irq is a single cycle wide.
- CSR decode:
  - Selected when csr_a[13:10]==csr_addr; word index is csr_a[3:0].
  - csr_do is updated every cycle: the register value when selected, else 0. Read latency is 1 cycle.
- CSR map:
  - 0: status/control. Read: bit0 valid, bit1 running (state!=IDLE), bit2 overrun, bits15:8 run_cnt, others 0. Write: bit0=1 clears valid; bit2=1 clears overrun; bit1 is specified under Optional Feature.
  - 1..7: shadow pixels, clocks, stall1, complete1, stall2, complete2, misses. Read-only.
  - 8: abort_cnt, 16-bit, saturates at 16'hFFFF, zero-extended.
  - 9..12: see Optional Feature.
  - 13..15: read 0.
  - Writes to read-only words are ignored.
- Simultaneous events:
  - CSR clear of valid in the CAPTURE cycle: capture wins, valid=1; overrun is computed from valid before the clear.
  - A clear of overrun in the same cycle as a capture that sets it: set wins.
  - CSR reads in the CAPTURE cycle return the old shadow value; the new value is visible from the next read.

Optional Feature:
- Macro TMU_PERFSNAP_ACCUM_EN.
- Defined:
  - 64-bit accumulators acc_clocks and acc_pixels add the live values at each CAPTURE; they wrap modulo 2^64.
  - CSR 9/10 = acc_clocks lo/hi; 11/12 = acc_pixels lo/hi.
  - A status write with bit1=1 clears both accumulators. If this coincides with CAPTURE, the clear wins and the accumulators read 0.
  - Reset clears both accumulators.
- Undefined: no accumulators; CSR 9..12 read 0; write bit1 is ignored.

Test Plan:
- Reset, then read CSR 0..12 -> all 0, irq=0.
- start; busy high 10 cycles; counters driven to pixels=100, clocks=10, misses=3; busy falls -> irq pulse exactly 3 cycles after busy=0. CSR1=100, CSR2=10, CSR7=3, CSR0=0x0000_0101.
- Second run (pixels=5) without clearing valid -> CSR0 bit2=1, CSR1=5, run_cnt=2. Write CSR0=0x5 -> CSR0=0x0000_0200.
- start pulse in RUN, then start in SETTLE -> CSR8=2, no irq; the run then completes normally -> run_cnt+1.
- Write CSR0 bit0=1 in the CAPTURE cycle -> valid reads 1. sys_rst_n low while in RUN -> IDLE, no irq, all registers 0.
- With TMU_PERFSNAP_ACCUM_EN, two runs of clocks=0xFFFF_FFFF -> CSR9=0xFFFF_FFFE, CSR10=1. Write CSR0 bit1 -> CSR9..12=0. Without the macro, CSR9..12 read 0 after the same runs.
